// File: rtl/ripple_adder.sv
// ripple_adder: parameterised unsigned ripple-carry adder with a single
// output register stage.
//
//   {o_carry, o_sum} = i_augend + i_addend + i_carry   (exact BITS+1-bit sum)
//   o_overflow       = carry into MSB ^ carry out of MSB (two's-complement)
//
// Ports
//   i_clock     rising-edge clock
//   i_reset     synchronous active-high reset, overrides i_valid
//   i_valid     operands valid this cycle
//   i_augend    first operand  [BITS-1:0]
//   i_addend    second operand [BITS-1:0]
//   i_carry     carry-in (weight 1)
//   o_valid     a new result was captured on the last edge
//   o_sum       low BITS bits of the sum
//   o_carry     carry-out
//   o_overflow  signed overflow flag
//
// Latency is one cycle. When i_valid is low the result registers keep their
// contents, so idle (possibly X) operands never reach the outputs.

// One bit of the carry chain.
module ripple_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic p;
  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);
endmodule

module ripple_adder #(
  parameter int BITS = 4
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_valid,
  input  logic [BITS-1:0] i_augend,
  input  logic [BITS-1:0] i_addend,
  input  logic            i_carry,
  output logic            o_valid,
  output logic [BITS-1:0] o_sum,
  output logic            o_carry,
  output logic            o_overflow
);

  // c[k] is the carry into bit k; c[BITS] is the carry-out.
  logic [BITS:0]   c;
  logic [BITS-1:0] s;

  assign c[0] = i_carry;

  for (genvar k = 0; k < BITS; k++) begin : g_bit
    ripple_adder_fa u_fa (
      .a_i (i_augend[k]),
      .b_i (i_addend[k]),
      .c_i (c[k]),
      .s_o (s[k]),
      .c_o (c[k+1])
    );
  end

  logic [BITS-1:0] sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;

  // Result registers only load on a valid beat; otherwise they hold.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    valid_d = i_valid;
    if (i_valid) begin
      sum_d   = s;
      carry_d = c[BITS];
      // For BITS=1 this is carry-in ^ carry-out.
      ovf_d   = c[BITS-1] ^ c[BITS];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_sum      = sum_q;
  assign o_carry    = carry_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_ripple_adder.sv
// Scoreboard bench for ripple_adder. The driver pushes the expected result of
// every accepted 4-bit beat into a queue; a monitor pops and compares on each
// cycle the DUT shows o_valid. Reset, hold and the 8-bit / 1-bit widths are
// checked directly.
module tb_ripple_adder;

  typedef struct packed {
    logic [3:0] sum;
    logic       c;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       vld;
  logic [3:0] a, b;
  logic       cin;
  logic       o_vld, o_c, o_ovf;
  logic [3:0] o_s;

  logic       vld8, cin8, o_vld8, o_c8, o_ovf8;
  logic [7:0] a8, b8, o_s8;

  logic       vld1, a1, b1, cin1, o_vld1, o_s1, o_c1, o_ovf1;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  ripple_adder #(.BITS(4)) u_dut4 (
    .i_clock(clk), .i_reset(rst), .i_valid(vld), .i_augend(a), .i_addend(b),
    .i_carry(cin), .o_valid(o_vld), .o_sum(o_s), .o_carry(o_c), .o_overflow(o_ovf)
  );

  ripple_adder #(.BITS(8)) u_dut8 (
    .i_clock(clk), .i_reset(rst), .i_valid(vld8), .i_augend(a8), .i_addend(b8),
    .i_carry(cin8), .o_valid(o_vld8), .o_sum(o_s8), .o_carry(o_c8), .o_overflow(o_ovf8)
  );

  ripple_adder #(.BITS(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_valid(vld1), .i_augend(a1), .i_addend(b1),
    .i_carry(cin1), .o_valid(o_vld1), .o_sum(o_s1), .o_carry(o_c1), .o_overflow(o_ovf1)
  );

  // Monitor: every result the 4-bit DUT presents must match the queue head.
  always @(negedge clk) begin
    if (o_vld === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: got sum=%0d c=%0b ovf=%0b, queue empty",
                 o_s, o_c, o_ovf);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({o_s, o_c, o_ovf} !== {e.sum, e.c, e.ovf}) begin
          n_err++;
          $display("FAIL result: got sum=%0d c=%0b ovf=%0b, want sum=%0d c=%0b ovf=%0b",
                   o_s, o_c, o_ovf, e.sum, e.c, e.ovf);
        end
      end
    end
  end

  // One beat on the 4-bit DUT; an accepted beat queues its expectation.
  task automatic drive(input logic [3:0] x, input logic [3:0] y, input logic ci,
                       input logic v, input exp_t e);
    @(negedge clk);
    a = x; b = y; cin = ci; vld = v;
    @(posedge clk);
    if (v) sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  initial begin
    exp_t e;
    int   t;
    // Reset beats with i_valid=1 and live operands on every instance.
    rst = 1'b1; vld = 1'b1; a = 4'd15; b = 4'd15; cin = 1'b1;
    vld8 = 1'b1; a8 = 8'd255; b8 = 8'd255; cin8 = 1'b1;
    vld1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {12'd0, o_vld, o_s, o_c, o_ovf} , 16'd0);
    check("reset_w8", {6'd0, o_vld8, o_s8, o_c8, o_ovf8}, 16'd0);
    check("reset_w1", {12'd0, o_vld1, o_s1, o_c1, o_ovf1}, 16'd0);
    rst = 1'b0; vld = 1'b0; vld8 = 1'b0; vld1 = 1'b0;

    // Directed boundary vectors, expectations worked out by hand.
    drive(4'd15, 4'd1,  1'b0, 1'b1, '{sum: 4'd0,  c: 1'b1, ovf: 1'b0});
    drive(4'd15, 4'd15, 1'b1, 1'b1, '{sum: 4'd15, c: 1'b1, ovf: 1'b0});
    drive(4'd7,  4'd1,  1'b0, 1'b1, '{sum: 4'd8,  c: 1'b0, ovf: 1'b1});
    drive(4'd8,  4'd8,  1'b0, 1'b1, '{sum: 4'd0,  c: 1'b1, ovf: 1'b1});
    drive(4'd0,  4'd0,  1'b0, 1'b1, '{sum: 4'd0,  c: 1'b0, ovf: 1'b0});
    drive(4'd0,  4'd0,  1'b1, 1'b1, '{sum: 4'd1,  c: 1'b0, ovf: 1'b0});

    // Hold: a valid 3+4, then an idle beat with different operands.
    drive(4'd3, 4'd4, 1'b0, 1'b1, '{sum: 4'd7, c: 1'b0, ovf: 1'b0});
    drive(4'd9, 4'd9, 1'b0, 1'b0, '{sum: 4'd0, c: 1'b0, ovf: 1'b0});
    @(negedge clk);
    check("hold_valid_low", {15'd0, o_vld}, 16'd0);
    check("hold_sum",       {12'd0, o_s},   16'd7);
    check("hold_carry",     {15'd0, o_c},   16'd0);

    // Width instances: 200+100 on 8 bits, 1+1+1 on 1 bit.
    a8 = 8'd200; b8 = 8'd100; cin8 = 1'b0; vld8 = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; vld1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld8 = 1'b0; vld1 = 1'b0;
    check("w8_sum",   {8'd0, o_s8},             16'd44);
    check("w8_flags", {13'd0, o_vld8, o_c8, o_ovf8}, 16'b110);
    check("w1_flags", {12'd0, o_vld1, o_s1, o_c1, o_ovf1}, 16'b1110);

    // Exhaustive 4-bit sweep, back-to-back. Overflow: same-sign operands
    // giving a result of the other sign.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int ci = 0; ci < 2; ci++) begin
          t     = x + y + ci;
          e.sum = t[3:0];
          e.c   = t[4];
          e.ovf = (x[3] == y[3]) && (t[3] != x[3]);
          drive(x[3:0], y[3:0], ci[0], 1'b1, e);
        end
    @(negedge clk);
    vld = 1'b0;

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results never presented, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
